// File: rtl/conv3x3_mac_if.sv
// Handshake, window/kernel and result bundle between the window buffer,
// the 3x3 convolver and the edge-threshold stage.
interface conv3x3_mac_if #(
  parameter int PIXEL_W = 4,
  parameter int COEF_W  = 5,
  parameter int OUT_W   = 10
) ();
  localparam int ACC_W = PIXEL_W + COEF_W + 4;

  logic                          calc_enable;
  logic                          abort;
  logic [2:0][2:0][PIXEL_W-1:0]  pixels;
  logic [2:0][2:0][COEF_W-1:0]   filter_x;
  logic [2:0][2:0][COEF_W-1:0]   filter_y;
  logic                          busy;
  logic                          calc_done;
  logic signed [ACC_W-1:0]       conv_x;
  logic signed [ACC_W-1:0]       conv_y;
  logic [OUT_W-1:0]              mag;

  modport master (
    output calc_enable, abort, pixels, filter_x, filter_y,
    input  busy, calc_done, conv_x, conv_y, mag
  );

  modport slave (
    input  calc_enable, abort, pixels, filter_x, filter_y,
    output busy, calc_done, conv_x, conv_y, mag
  );
endinterface

// File: rtl/conv3x3_mac.sv
// Dual-kernel 3x3 convolver: one shared MAC per channel, one tap per clock,
// followed by a saturated edge magnitude (sum or max of absolute values).
//
// state | meaning
// IDLE  | waiting for calc_enable; results held
// MAC   | accumulating taps 0..8, one per clock
module conv3x3_mac #(
  parameter int PIXEL_W = 4,
  parameter int COEF_W  = 5,
  parameter int OUT_W   = 10,
  parameter bit MAG_SEL = 1'b0
) (
  input  logic         clk,
  input  logic         n_rst,
  conv3x3_mac_if.slave bus
);
  localparam int ACC_W = PIXEL_W + COEF_W + 4;
  localparam int CMB_W = ACC_W + 1;
  localparam int SAT_W = (CMB_W > OUT_W) ? CMB_W : OUT_W;
  localparam logic [SAT_W-1:0] MAG_MAX = SAT_W'((2 ** OUT_W) - 1);

  typedef enum logic {IDLE, MAC} state_t;

  state_t state, state_next;

  logic [8:0][PIXEL_W-1:0] pix_r;
  logic [8:0][COEF_W-1:0]  fx_r;
  logic [8:0][COEF_W-1:0]  fy_r;
  logic [3:0]              tap;
  logic signed [ACC_W-1:0] acc_x, acc_y;
  logic signed [ACC_W-1:0] pix_ext, cx_ext, cy_ext;
  logic signed [ACC_W-1:0] sum_x, sum_y;
  logic [ACC_W-1:0]        abs_x, abs_y;
  logic [CMB_W-1:0]        combined;
  logic [SAT_W-1:0]        combined_w;
  logic [OUT_W-1:0]        mag_next;
  logic                    start, last_tap;
  logic                    busy_r, done_r;
  logic signed [ACC_W-1:0] conv_x_r, conv_y_r;
  logic [OUT_W-1:0]        mag_r;

  assign start    = (state == IDLE) && bus.calc_enable;
  assign last_tap = (tap == 4'd8);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.calc_enable) state_next = MAC;
      MAC:  if (bus.abort || last_tap) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Packed [row][col] flattens so that element row*3+col is tap k, row-major.
  always_comb begin
    pix_ext = signed'({{(ACC_W-PIXEL_W){1'b0}}, pix_r[tap]});
    cx_ext  = ACC_W'(signed'(fx_r[tap]));
    cy_ext  = ACC_W'(signed'(fy_r[tap]));
    sum_x   = acc_x + pix_ext * cx_ext;
    sum_y   = acc_y + pix_ext * cy_ext;
  end

  always_comb begin
    abs_x = sum_x[ACC_W-1] ? ACC_W'(-sum_x) : ACC_W'(sum_x);
    abs_y = sum_y[ACC_W-1] ? ACC_W'(-sum_y) : ACC_W'(sum_y);
    if (MAG_SEL)
      combined = CMB_W'((abs_x > abs_y) ? abs_x : abs_y);
    else
      combined = CMB_W'(abs_x) + CMB_W'(abs_y);
    combined_w = SAT_W'(combined);
    mag_next   = (combined_w > MAG_MAX) ? OUT_W'(MAG_MAX) : OUT_W'(combined_w);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pix_r    <= '0;
      fx_r     <= '0;
      fy_r     <= '0;
      tap      <= '0;
      acc_x    <= '0;
      acc_y    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      conv_x_r <= '0;
      conv_y_r <= '0;
      mag_r    <= '0;
    end else if (start) begin
      pix_r  <= bus.pixels;
      fx_r   <= bus.filter_x;
      fy_r   <= bus.filter_y;
      tap    <= '0;
      acc_x  <= '0;
      acc_y  <= '0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (state == MAC) begin
      if (bus.abort) begin
        busy_r <= 1'b0;
        done_r <= 1'b0;
      end else if (last_tap) begin
        conv_x_r <= sum_x;
        conv_y_r <= sum_y;
        mag_r    <= mag_next;
        busy_r   <= 1'b0;
        done_r   <= 1'b1;
      end else begin
        acc_x <= sum_x;
        acc_y <= sum_y;
        tap   <= tap + 4'd1;
      end
    end
  end

  assign bus.busy      = busy_r;
  assign bus.calc_done = done_r;
  assign bus.conv_x    = conv_x_r;
  assign bus.conv_y    = conv_y_r;
  assign bus.mag       = mag_r;
endmodule
